// File: rtl/mux2_to_1_pkg.sv
// Shared definitions for the mux family: select encoding used by the 2:1 leaf
// and by composite muxes built from it.
package mux2_to_1_pkg;

    localparam logic SEL_I0 = 1'b0;
    localparam logic SEL_I1 = 1'b1;

endpackage

// File: rtl/mux2_to_1.sv
// Parameterised 2:1 multiplexer, out = sel ? i1 : i0, with an optional
// registered output (REG_OUT=1: synchronous reset, load enable, 1-cycle latency).
module mux2_to_1
    import mux2_to_1_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter bit          REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] selected;

    // A ternary keeps X propagation on an unknown select in simulation.
    assign selected = (sel == SEL_I1) ? i1 : i0;

    generate
        if (REG_OUT) begin : g_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    out <= '0;
                end else if (en) begin
                    out <= selected;
                end
            end
        end else begin : g_comb
            // Clock, reset and enable are intentionally unused on this path.
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, reset, en};
            assign out = selected;
        end
    endgenerate

endmodule

// File: tb/tb_mux2_to_1.sv
// Scoreboard bench for mux2_to_1: combinational 1-bit and 8-bit builds,
// registered 8-bit build, and a 4:1 tree of three 1-bit leaves.
module tb_mux2_to_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [7:0] sb_q[$];

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] got);
        logic [7:0] exp;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty, got %h", tag, got);
        end else begin
            exp = sb_q.pop_front();
            check_eq(tag, got, exp);
        end
    endtask

    // 1-bit combinational
    logic c1_i0, c1_i1, c1_sel, c1_out;
    mux2_to_1 #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (
        .clk(clk), .reset(1'b0), .i0(c1_i0), .i1(c1_i1),
        .sel(c1_sel), .en(1'b0), .out(c1_out)
    );

    // 8-bit combinational
    logic [7:0] c8_i0, c8_i1, c8_out;
    logic       c8_sel;
    mux2_to_1 #(.WIDTH(8), .REG_OUT(1'b0)) u_c8 (
        .clk(clk), .reset(1'b0), .i0(c8_i0), .i1(c8_i1),
        .sel(c8_sel), .en(1'b0), .out(c8_out)
    );

    // 8-bit registered
    logic [7:0] r_i0, r_i1, r_out;
    logic       r_sel, r_en, r_rst;
    mux2_to_1 #(.WIDTH(8), .REG_OUT(1'b1)) u_r8 (
        .clk(clk), .reset(r_rst), .i0(r_i0), .i1(r_i1),
        .sel(r_sel), .en(r_en), .out(r_out)
    );

    // 4:1 tree: low select on the first level, high select at the root
    logic [3:0] t_in;
    logic       t_lo, t_hi, t_a, t_b, t_out;
    mux2_to_1 #(.WIDTH(1), .REG_OUT(1'b0)) u_t0 (
        .clk(clk), .reset(1'b0), .i0(t_in[0]), .i1(t_in[1]),
        .sel(t_lo), .en(1'b0), .out(t_a)
    );
    mux2_to_1 #(.WIDTH(1), .REG_OUT(1'b0)) u_t1 (
        .clk(clk), .reset(1'b0), .i0(t_in[2]), .i1(t_in[3]),
        .sel(t_lo), .en(1'b0), .out(t_b)
    );
    mux2_to_1 #(.WIDTH(1), .REG_OUT(1'b0)) u_t2 (
        .clk(clk), .reset(1'b0), .i0(t_a), .i1(t_b),
        .sel(t_hi), .en(1'b0), .out(t_out)
    );

    // Reference state of the registered output
    logic [7:0] model_q = 8'h00;

    task automatic reg_step(input string tag, input logic rst, input logic en,
                            input logic sel, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        r_rst = rst; r_en = en; r_sel = sel; r_i0 = a; r_i1 = b;
        #1;
        check_eq({tag, "_hold"}, r_out, model_q);
        if (rst)     model_q = 8'h00;
        else if (en) model_q = sel ? b : a;
        sb_q.push_back(model_q);
        @(posedge clk);
        #1;
        pop_check(tag, r_out);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [1:0] idx;
        logic [3:0] vals;
        c1_i0 = 0; c1_i1 = 0; c1_sel = 0;
        c8_i0 = 0; c8_i1 = 0; c8_sel = 0;
        r_i0 = 0; r_i1 = 0; r_sel = 0; r_en = 0; r_rst = 1;
        t_in = 0; t_lo = 0; t_hi = 0;

        // Exhaustive 1-bit combinational
        for (int v = 0; v < 8; v++) begin
            {c1_sel, c1_i1, c1_i0} = 3'(v);
            sb_q.push_back(c1_sel ? {7'b0, c1_i1} : {7'b0, c1_i0});
            #10;
            pop_check("c1", {7'b0, c1_out});
        end

        // 8-bit combinational
        c8_i0 = 8'hA5; c8_i1 = 8'h3C;
        c8_sel = 0; sb_q.push_back(8'hA5); #10; pop_check("c8_sel0", c8_out);
        c8_sel = 1; sb_q.push_back(8'h3C); #10; pop_check("c8_sel1", c8_out);
        c8_i0 = 8'h66; c8_i1 = 8'h66;
        c8_sel = 0; sb_q.push_back(8'h66); #10; pop_check("c8_eq0", c8_out);
        c8_sel = 1; sb_q.push_back(8'h66); #10; pop_check("c8_eq1", c8_out);

        // 4:1 tree, all 64 combinations
        for (int v = 0; v < 64; v++) begin
            vals = 4'(v);
            idx  = 2'(v >> 4);
            t_in = vals; t_lo = idx[0]; t_hi = idx[1];
            sb_q.push_back({7'b0, vals[idx]});
            #10;
            pop_check("tree", {7'b0, t_out});
        end

        // Registered: first two reset edges (output unknown before the first)
        @(negedge clk);
        r_rst = 1; r_en = 0;
        sb_q.push_back(8'h00);
        @(posedge clk); #1; pop_check("rst_edge1", r_out);
        reg_step("rst_edge2", 1, 0, 0, 8'h00, 8'h00);
        reg_step("load_ff",   0, 1, 1, 8'h00, 8'hFF);
        reg_step("en0_a",     0, 0, 0, 8'h11, 8'hFF);
        reg_step("en0_b",     0, 0, 0, 8'h11, 8'hFF);
        reg_step("load_11",   0, 1, 0, 8'h11, 8'hFF);
        reg_step("mid_rst",   1, 0, 0, 8'h11, 8'hFF);
        reg_step("load_aa",   0, 1, 1, 8'h00, 8'hAA);
        reg_step("rst_pri",   1, 1, 1, 8'h00, 8'h77);
        reg_step("eq_sel0",   0, 1, 0, 8'h5A, 8'h5A);
        reg_step("eq_sel1",   0, 1, 1, 8'h5A, 8'h5A);
        for (int k = 0; k < 12; k++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            reg_step("rand", 1'($urandom_range(0, 7) == 0), 1'($urandom),
                     1'($urandom), ra, rb);
        end

        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL sb_leftover: %0d entries left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
